// File: rtl/cpu_pkg.sv
// +-----------------------------------------------------------------------------
// | cpu_pkg : shared ISA encodings and decoder control bundle for the core.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001001;
    localparam logic [5:0] c_op_lw    = 6'b101100;
    localparam logic [5:0] c_op_sw    = 6'b100100;
    localparam logic [5:0] c_op_beq   = 6'b000110;
    localparam logic [5:0] c_op_bne   = 6'b000101;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;

    localparam logic [1:0] c_regdst_rt = 2'b00;
    localparam logic [1:0] c_regdst_rd = 2'b01;

    localparam logic [1:0] c_branch_none = 2'b00;
    localparam logic [1:0] c_branch_eq   = 2'b01;
    localparam logic [1:0] c_branch_ne   = 2'b10;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
    } ctrl_t;

    localparam ctrl_t c_ctrl_nop = '0;

    function automatic logic uses_rs(input logic [5:0] op);
        case (op)
            c_op_rtype, c_op_addi, c_op_lw, c_op_sw, c_op_beq, c_op_bne: uses_rs = 1'b1;
            default:                                                      uses_rs = 1'b0;
        endcase
    endfunction

    // ADDI and LW write rt, so rt is not a source for them
    function automatic logic uses_rt(input logic [5:0] op);
        case (op)
            c_op_rtype, c_op_sw, c_op_beq, c_op_bne: uses_rt = 1'b1;
            default:                                 uses_rt = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_hazard.sv
// +-----------------------------------------------------------------------------
// | id_ex_hazard : combinational load-use hazard detect against the EX slot.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module id_ex_hazard
    import cpu_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [5:0] id_op_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_dst_i,
    output logic       hazard_o
);

    logic w_ex_load;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_ex_load = ex_valid_i && ex_memread_i && (ex_dst_i != 5'd0);
    assign w_rs_hit  = uses_rs(id_op_i) && (id_rs_i == ex_dst_i);
    assign w_rt_hit  = uses_rt(id_op_i) && (id_rt_i == ex_dst_i);
    assign hazard_o  = w_ex_load && id_valid_i && (w_rs_hit || w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +-----------------------------------------------------------------------------
// | id_ex_stage : ID/EX pipeline register with load-use stall and flush squash.
// | Optional ID_EX_PERF_CNT_EN adds stall/flush event counters.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        id_valid_i,
    input  logic [5:0]  id_op_i,
    input  logic [1:0]  id_aluop_i,
    input  logic        id_alusrc_i,
    input  logic        id_regwrite_i,
    input  logic [1:0]  id_regdst_i,
    input  logic [1:0]  id_branch_i,
    input  logic        id_memread_i,
    input  logic        id_memwrite_i,
    input  logic        id_memtoreg_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic [31:0] id_rs_data_i,
    input  logic [31:0] id_rt_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [31:0] id_pc4_i,
    input  logic [5:0]  id_funct_i,
    output logic [1:0]  ex_aluop_o,
    output logic        ex_alusrc_o,
    output logic        ex_regwrite_o,
    output logic [1:0]  ex_regdst_o,
    output logic [1:0]  ex_branch_o,
    output logic        ex_memread_o,
    output logic        ex_memwrite_o,
    output logic        ex_memtoreg_o,
    output logic [4:0]  ex_rs_o,
    output logic [4:0]  ex_rt_o,
    output logic [4:0]  ex_rd_o,
    output logic [31:0] ex_rs_data_o,
    output logic [31:0] ex_rt_data_o,
    output logic [31:0] ex_imm_o,
    output logic [31:0] ex_pc4_o,
    output logic [5:0]  ex_funct_o,
    output logic        ex_valid_o,
    output logic [4:0]  ex_dst_o,
    output logic        stall_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    ctrl_t       w_id_ctrl;
    ctrl_t       r_ctrl;
    logic        r_valid;
    logic [4:0]  r_rs, r_rt, r_rd, r_dst;
    logic [31:0] r_rs_data, r_rt_data, r_imm, r_pc4;
    logic [5:0]  r_funct;
    logic        w_hazard;

    assign w_id_ctrl = '{aluop:    id_aluop_i,
                         alusrc:   id_alusrc_i,
                         regwrite: id_regwrite_i,
                         regdst:   id_regdst_i,
                         branch:   id_branch_i,
                         memread:  id_memread_i,
                         memwrite: id_memwrite_i,
                         memtoreg: id_memtoreg_i};

    id_ex_hazard u_hazard (
        .id_valid_i   (id_valid_i),
        .id_op_i      (id_op_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .ex_valid_i   (r_valid),
        .ex_memread_i (r_ctrl.memread),
        .ex_dst_i     (r_dst),
        .hazard_o     (w_hazard)
    );

    // A flush already discards the ID instruction, so holding IF/ID is pointless
    assign stall_o = w_hazard && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= c_ctrl_nop;
            r_valid   <= 1'b0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_dst     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_pc4     <= '0;
            r_funct   <= '0;
        end else if (flush_i || w_hazard) begin
            r_ctrl    <= c_ctrl_nop;
            r_valid   <= 1'b0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_dst     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_pc4     <= '0;
            r_funct   <= '0;
        end else begin
            r_ctrl    <= w_id_ctrl;
            r_valid   <= id_valid_i;
            r_rs      <= id_rs_i;
            r_rt      <= id_rt_i;
            r_rd      <= id_rd_i;
            r_dst     <= (id_regdst_i == c_regdst_rd) ? id_rd_i : id_rt_i;
            r_rs_data <= id_rs_data_i;
            r_rt_data <= id_rt_data_i;
            r_imm     <= id_imm_i;
            r_pc4     <= id_pc4_i;
            r_funct   <= id_funct_i;
        end
    end

    assign ex_aluop_o    = r_ctrl.aluop;
    assign ex_alusrc_o   = r_ctrl.alusrc;
    assign ex_regwrite_o = r_ctrl.regwrite;
    assign ex_regdst_o   = r_ctrl.regdst;
    assign ex_branch_o   = r_ctrl.branch;
    assign ex_memread_o  = r_ctrl.memread;
    assign ex_memwrite_o = r_ctrl.memwrite;
    assign ex_memtoreg_o = r_ctrl.memtoreg;
    assign ex_rs_o       = r_rs;
    assign ex_rt_o       = r_rt;
    assign ex_rd_o       = r_rd;
    assign ex_rs_data_o  = r_rs_data;
    assign ex_rt_data_o  = r_rt_data;
    assign ex_imm_o      = r_imm;
    assign ex_pc4_o      = r_pc4;
    assign ex_funct_o    = r_funct;
    assign ex_valid_o    = r_valid;
    assign ex_dst_o      = r_dst;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_i && id_valid_i)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between the instruction decoder (ID) and the execute stage (EX) of the 5-stage MIPS-subset core. It captures the decoder's control bundle and the ID operands, and detects load-use hazards against the instruction already in EX. On a hazard it inserts a bubble and asks PC/IF-ID to hold. It also squashes the ID/EX contents on a taken-branch flush.

## Interface
- No parameters; widths are fixed by the ISA (5-bit register numbers, 32-bit data).
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  taken branch resolved downstream; squash the instruction entering EX.
- id_valid_i  in  1  the IF/ID register holds a real instruction.
- id_op_i  in  6  opcode of the ID instruction; used for source-register usage.
- id_aluop_i / id_alusrc_i / id_regwrite_i / id_regdst_i / id_branch_i / id_memread_i / id_memwrite_i / id_memtoreg_i  in  2/1/1/2/2/1/1/1  decoder control bundle.
- id_rs_i, id_rt_i, id_rd_i  in  5 each  register numbers.
- id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i  in  32 each  operands, sign-extended immediate, PC+4.
- id_funct_i  in  6  funct field.
- ex_* outputs  out  widths as inputs  registered copies of every id_* input except id_op_i and id_valid_i.
- ex_valid_o  out  1  EX slot holds a real instruction.
- ex_dst_o  out  5  destination register: id_rd_i if id_regdst_i==2'b01, else id_rt_i.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.

## Operation
- Opcodes: R-type 6'b000000, ADDI 6'b001001, LW 6'b101100, SW 6'b100100, BEQ 6'b000110, BNE 6'b000101.
- Source usage:
  - rs is used by all six opcodes.
  - rt is used by R-type, SW, BEQ and BNE only.
  - Unknown opcodes use neither.
- Hazard condition, all of the following true:
  - ex_valid_o and ex_memread_o.
  - ex_dst_o != 0.
  - id_valid_i.
  - ex_dst_o equals a used source (rs, rt, or both).
- stall_o = hazard & ~flush_i.
- Per-edge update, in priority order:
  1. flush_i: load a bubble.
  2. hazard: load a bubble.
  3. Otherwise: load the ID inputs, with ex_valid_o = id_valid_i.
- Bubble definition:
  - All control outputs 0 and ex_valid_o = 0.
  - All data, register and funct outputs 0.
  - ex_dst_o = 0.
- If id_valid_i = 0, the ID fields are loaded as given but ex_valid_o = 0. Downstream ignores controls when ex_valid_o = 0.
- A hazard lasts exactly one cycle: the bubble clears ex_memread_o, so the stalled instruction advances on the next edge.

## Timing
- Latency is one cycle from ID inputs to ex_* outputs.
- stall_o is valid in the same cycle as the inputs and has no registered delay.
- Reset (asynchronous, rst_n low): every registered output becomes 0, including ex_valid_o. stall_o evaluates to 0 because ex_valid_o = 0.
- Reset deasserted mid-stream: the first edge after release loads normally.
- Flush and hazard in the same cycle: flush wins, stall_o = 0, and a bubble is loaded.
- Back-to-back LW, LW with a dependency: one stall, then the second LW is checked against the first normally.

## Configuration
- ID_EX_PERF_CNT_EN defined adds two outputs:
  - stall_cnt_o (32-bit): increments on every edge where stall_o = 1.
  - flush_cnt_o (32-bit): increments on every edge where flush_i = 1 and ex_valid would otherwise have been loaded as 1 (id_valid_i = 1).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams;
  - ALUOp encodings (00 add, 01 sub, 10 R-type);
  - RegDst and Branch encodings;
  - a packed ctrl_t struct for the decoder bundle.
- One combinational sub-module, id_ex_hazard, computes the hazard signal from the ID register numbers, id_op_i and the EX dst/memread/valid.

## Test plan
- Reset: hold rst_n low mid-run with ex_valid_o = 1 → all outputs 0 asynchronously, before the next edge.
- Pass-through: ADDI with rt = 5, rd = 9, imm = 0xFFFFFFFC → the next cycle shows ex_dst_o = 5, ex_alusrc_o = 1, ex_imm_o = 0xFFFFFFFC, ex_valid_o = 1.
- Load-use on rs: LW to $8, then ADDI reading rs = $8 → stall_o = 1 for one cycle, one bubble, then ADDI enters EX with ex_valid_o = 1.
- Load-use on rt is opcode-sensitive:
  - LW to $8, then ADDI with rt = 8 and rs = 3 → no stall.
  - LW to $8, then SW with rt = 8 → stall_o = 1.
- Special cases:
  - LW to $0, then R-type reading $0 → stall_o = 0.
  - flush_i with a simultaneous hazard → stall_o = 0 and bubble loaded (with ID_EX_PERF_CNT_EN: stall_cnt_o unchanged, flush_cnt_o +1).
- Counters (ID_EX_PERF_CNT_EN): force stall_cnt_o to 0xFFFFFFFF via a stall sequence preload in simulation, then one more stall → wraps to 0.
